// File: rtl/sync_1111_framer_pkg.sv
// ---------------------------------------------------------------------------
// sync_1111_framer_pkg
//
// Purpose: constants and types shared by the 1111 sync framer and the
// benches that check it. These include the FSM state encoding, the
// sync-marker length, the ones-run limit that triggers a stuffed zero,
// and the fixed separator and trailer bit values.
//
// Ports: none (package).
// ---------------------------------------------------------------------------
package sync_1111_framer_pkg;

    // Framer FSM states, 3-bit encoding.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SYNC  = 3'd1,
        ST_SEP   = 3'd2,
        ST_DATA  = 3'd3,
        ST_STUFF = 3'd4,
        ST_TRAIL = 3'd5
    } state_t;

    // Number of consecutive 1s forming the sync marker.
    localparam int unsigned SYNC_LEN   = 4;
    localparam int unsigned SYNC_CNT_W = $clog2(SYNC_LEN);

    // A run of this many payload 1s forces a stuffed 0, so the line
    // never carries SYNC_LEN ones outside the marker.
    localparam logic [1:0]  RUN_MAX    = 2'd3;

    // Fixed bit values framing the payload.
    localparam logic        SEP_BIT    = 1'b0;
    localparam logic        TRAIL_BIT  = 1'b0;

    // Ones-run update for one payload bit: count 1s, saturating at RUN_MAX,
    // and restart on a 0.
    function automatic logic [1:0] runStep(input logic [1:0] run, input logic bitVal);
        logic [1:0] result;
        if (!bitVal) begin
            result = 2'd0;
        end else if (run == RUN_MAX) begin
            result = RUN_MAX;
        end else begin
            result = run + 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sync_1111_framer.sv
// ---------------------------------------------------------------------------
// sync_1111_framer
//
// Purpose: serial frame transmitter for the 1111 sequence detector.
// Each frame is sent one bit per clock in this order: the 1111 sync
// marker, a 0 separator, the payload MSB-first with a 0 stuffed after
// every third consecutive 1, and finally a 0 trailer.
//
// Ports:
//   clk          in   rising-edge clock
//   reset        in   asynchronous active-high reset
//   start        in   frame request, honoured only while ready=1
//   data_in      in   DATA_W-bit payload, captured when start is accepted
//   ready        out  idle, able to accept start (decoded from state)
//   w            out  registered serial line bit
//   frame_active out  registered, high for every frame bit
//   done         out  registered one-cycle pulse during the trailer bit
// ---------------------------------------------------------------------------
module sync_1111_framer
    import sync_1111_framer_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    output logic              ready,
    output logic              w,
    output logic              frame_active,
    output logic              done
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t                  r_state;
    state_t                  w_nextState;
    logic [SYNC_CNT_W-1:0]   r_syncCnt;
    logic [SYNC_CNT_W-1:0]   w_nextSyncCnt;
    logic [CNT_W-1:0]        r_bitCnt;
    logic [CNT_W-1:0]        w_nextBitCnt;
    logic [1:0]              r_runCnt;
    logic [1:0]              w_nextRunCnt;
    logic [DATA_W-1:0]       r_shift;
    logic [DATA_W-1:0]       w_nextShift;
    logic                    r_w;
    logic                    r_frameActive;
    logic                    r_done;
    logic                    w_nextW;
    logic                    w_nextFrameActive;
    logic                    w_nextDone;
    logic [1:0]              w_runAfterBit;
    logic                    w_lastBit;

    // Next-state logic for the FSM, shift register and counters. The
    // registered outputs are derived from the *next* state and shift
    // value. As a result, w/frame_active/done appear in the same cycle
    // as the state they describe, while still coming straight out of
    // flops with no combinational path from the inputs.
    always_comb begin
        w_nextState   = r_state;
        w_nextSyncCnt = r_syncCnt;
        w_nextBitCnt  = r_bitCnt;
        w_nextRunCnt  = r_runCnt;
        w_nextShift   = r_shift;
        w_runAfterBit = runStep(r_runCnt, r_shift[DATA_W-1]);
        w_lastBit     = (r_bitCnt == CNT_W'(DATA_W - 1));

        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_nextShift   = data_in;
                    w_nextSyncCnt = '0;
                    w_nextBitCnt  = '0;
                    w_nextRunCnt  = '0;
                    w_nextState   = ST_SYNC;
                end
            end
            ST_SYNC: begin
                if (r_syncCnt == SYNC_CNT_W'(SYNC_LEN - 1)) begin
                    w_nextSyncCnt = '0;
                    w_nextState   = ST_SEP;
                end else begin
                    w_nextSyncCnt = r_syncCnt + 1'b1;
                end
            end
            ST_SEP: begin
                w_nextRunCnt = '0;
                w_nextState  = ST_DATA;
            end
            ST_DATA: begin
                // The run check takes priority over the bit count, so a
                // third 1 in the last payload position still gets stuffed.
                w_nextShift  = r_shift << 1;
                w_nextBitCnt = r_bitCnt + 1'b1;
                w_nextRunCnt = w_runAfterBit;
                if (w_runAfterBit == RUN_MAX) begin
                    w_nextState = ST_STUFF;
                end else if (w_lastBit) begin
                    w_nextState = ST_TRAIL;
                end
            end
            ST_STUFF: begin
                w_nextRunCnt = '0;
                if (r_bitCnt == CNT_W'(DATA_W)) begin
                    w_nextState = ST_TRAIL;
                end else begin
                    w_nextState = ST_DATA;
                end
            end
            ST_TRAIL: begin
                w_nextState = ST_IDLE;
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase

        w_nextW = 1'b0;
        case (w_nextState)
            ST_SYNC:  w_nextW = 1'b1;
            ST_SEP:   w_nextW = SEP_BIT;
            ST_DATA:  w_nextW = w_nextShift[DATA_W-1];
            ST_TRAIL: w_nextW = TRAIL_BIT;
            default:  w_nextW = 1'b0;
        endcase
        w_nextFrameActive = (w_nextState != ST_IDLE);
        w_nextDone        = (w_nextState == ST_TRAIL);
    end

    // State, datapath and output registers. Reset at any time, including
    // mid-frame, returns to a silent idle line.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state       <= ST_IDLE;
            r_syncCnt     <= '0;
            r_bitCnt      <= '0;
            r_runCnt      <= '0;
            r_shift       <= '0;
            r_w           <= 1'b0;
            r_frameActive <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_syncCnt     <= w_nextSyncCnt;
            r_bitCnt      <= w_nextBitCnt;
            r_runCnt      <= w_nextRunCnt;
            r_shift       <= w_nextShift;
            r_w           <= w_nextW;
            r_frameActive <= w_nextFrameActive;
            r_done        <= w_nextDone;
        end
    end

    assign ready        = (r_state == ST_IDLE);
    assign w            = r_w;
    assign frame_active = r_frameActive;
    assign done         = r_done;

endmodule
